// File: rtl/sram_ctrl_if.sv
// Request/response bus between the datapath and the SRAM controller.
// The master issues commands; the slave (controller) returns completion and read data.
interface sram_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              done;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, done, rd_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, done, rd_data
  );
endinterface

// File: rtl/sram_ctrl.sv
// Front end for the 2K x 8 asynchronous SRAM: one command per handshake,
// strobes sequenced as setup / pulse / hold, all outputs registered.
module sram_ctrl #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sram_ctrl_if.slave        req,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_din,
  input  logic [DATA_W-1:0] i_sram_dout,
  output logic              o_sram_ce_n,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n
);

  localparam int MAX_CNT = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WSETUP, S_WPULSE, S_WHOLD, S_RACC, S_RDONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_accept;

  logic              r_ready;
  logic              r_done;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_din;
  logic              r_ce_n;
  logic              r_we_n;
  logic              r_oe_n;

  logic              w_ready_nxt;
  logic              w_done_nxt;
  logic              w_ce_n_nxt;
  logic              w_we_n_nxt;
  logic              w_oe_n_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req.req_valid) begin
          w_accept = 1'b1;
          if (req.req_write) begin
            w_state_nxt = S_WSETUP;
          end else begin
            w_state_nxt = S_RACC;
            w_cnt_nxt   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      S_WSETUP: begin
        w_state_nxt = S_WPULSE;
        w_cnt_nxt   = CNT_W'(WR_PULSE - 1);
      end
      S_WPULSE: begin
        if (r_cnt == '0) w_state_nxt = S_WHOLD;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_WHOLD: w_state_nxt = S_IDLE;
      S_RACC: begin
        if (r_cnt == '0) w_state_nxt = S_RDONE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_RDONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_done_nxt  = (w_state_nxt == S_WHOLD) || (w_state_nxt == S_RDONE);
    w_ce_n_nxt  = !((w_state_nxt == S_WSETUP) || (w_state_nxt == S_WPULSE) ||
                    (w_state_nxt == S_WHOLD)  || (w_state_nxt == S_RACC));
    w_we_n_nxt  = (w_state_nxt != S_WPULSE);
    w_oe_n_nxt  = (w_state_nxt != S_RACC);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_rd_data   <= '0;
      r_sram_addr <= '0;
      r_sram_din  <= '0;
      r_ce_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
    end else begin
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      r_ce_n  <= w_ce_n_nxt;
      r_we_n  <= w_we_n_nxt;
      r_oe_n  <= w_oe_n_nxt;
      if (w_accept) begin
        r_sram_addr <= req.req_addr;
        r_sram_din  <= req.req_wdata;
      end
      if ((r_state == S_RACC) && (r_cnt == '0)) r_rd_data <= i_sram_dout;
    end
  end

  assign req.req_ready = r_ready;
  assign req.done      = r_done;
  assign req.rd_data   = r_rd_data;
  assign o_sram_addr   = r_sram_addr;
  assign o_sram_din    = r_sram_din;
  assign o_sram_ce_n   = r_ce_n;
  assign o_sram_we_n   = r_we_n;
  assign o_sram_oe_n   = r_oe_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM, shadow memory and a queue of expected
// completions popped on each done pulse.
module tb_sram_ctrl;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 8;
  localparam int WR_PULSE = 2;
  localparam int RD_WAIT  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;

  sram_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_PULSE(WR_PULSE), .RD_WAIT(RD_WAIT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .req         (bus.slave),
    .o_sram_addr (sram_addr),
    .o_sram_din  (sram_din),
    .i_sram_dout (sram_dout),
    .o_sram_ce_n (sram_ce_n),
    .o_sram_we_n (sram_we_n),
    .o_sram_oe_n (sram_oe_n)
  );

  // Behavioural SRAM
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_din;
  assign sram_dout = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : '0;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              known;
    int                acc;
  } exp_t;

  exp_t              sbq[$];
  logic [DATA_W-1:0] shadow  [0:(1<<ADDR_W)-1];
  logic              known_m [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] last_rd    = '0;
  logic              last_known = 1'b1;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at the negedge before the accepting edge.
  task automatic push_exp(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    e.wr   = wr;
    e.addr = a;
    e.acc  = cyc + 1;
    if (wr) begin
      e.data     = d;
      e.known    = 1'b1;
      shadow[a]  = d;
      known_m[a] = 1'b1;
    end else begin
      e.data  = shadow[a];
      e.known = known_m[a];
    end
    sbq.push_back(e);
  endtask

  task automatic do_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
    end else begin
      push_exp(wr, a, d);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Monitor: invariants, write pulse width, completions
  int                we_cnt = 0;
  logic              prev_ce_low = 1'b0;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pdin;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      we_cnt      = 0;
      prev_ce_low = 1'b0;
    end else begin
      chk("strobe_inv", {30'd0, ~sram_we_n & ~sram_oe_n, ~sram_we_n & sram_ce_n}, 32'd0);
      if (prev_ce_low && !sram_ce_n) chk("addr_din_stable", {sram_addr, sram_din}, {paddr, pdin});
      if (!sram_we_n) we_cnt++;
      else if (we_cnt != 0) begin
        chk("we_width", we_cnt, WR_PULSE);
        we_cnt = 0;
      end
      if (bus.done) begin
        if (sbq.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk(e.wr ? "wr_latency" : "rd_latency", cyc - e.acc + 1, e.wr ? 2 + WR_PULSE : RD_WAIT + 1);
          if (!e.wr) begin
            if (e.known) chk("rd_data", bus.rd_data, e.data);
            last_rd    = e.data;
            last_known = e.known;
          end else if (last_known) begin
            chk("rd_hold_on_write", bus.rd_data, last_rd);
          end
        end
      end
      prev_ce_low = !sram_ce_n;
      paddr       = sram_addr;
      pdin        = sram_din;
    end
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                n;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      shadow[i]  = '0;
      known_m[i] = 1'b0;
    end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = '0;
    bus.req_wdata = 8'hFF;

    // Reset held with a pending command
    repeat (3) begin
      @(negedge clk);
      chk("rst_state", {27'd0, bus.req_ready, sram_ce_n, sram_we_n, sram_oe_n, bus.done}, 32'b11110);
    end
    #1 rst_n = 1'b1;
    push_exp(1'b1, '0, 8'hFF);
    @(negedge clk);
    chk("accept_after_rst", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);

    // Write then read, address isolation, unwritten read
    do_cmd(1'b0, 11'h000, 8'h00);
    do_cmd(1'b1, 11'h7FF, 8'hA5);
    do_cmd(1'b1, 11'h001, 8'h3C);
    do_cmd(1'b0, 11'h7FF, 8'h00);
    do_cmd(1'b0, 11'h001, 8'h00);
    do_cmd(1'b0, 11'h400, 8'h00);
    do_cmd(1'b0, 11'h7FF, 8'h00);

    // Busy hold-off: valid stays high with changing fields during a write
    do_cmd(1'b1, 11'h123, 8'h99);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req_addr  = ADDR_W'($urandom);
      bus.req_wdata = DATA_W'($urandom);
      bus.req_write = 1'($urandom);
      chk("busy_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("busy_addr", {21'd0, sram_addr}, {21'd0, 11'h123});
      chk("busy_din", {24'd0, sram_din}, 32'h99);
    end
    do_cmd(1'b1, 11'h124, 8'h66);
    do_cmd(1'b0, 11'h123, 8'h00);
    do_cmd(1'b0, 11'h124, 8'h00);

    // Random stream
    for (int k = 0; k < 200; k++) begin
      a = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      d = DATA_W'($urandom);
      do_cmd(1'($urandom_range(0, 1)), a, d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(8);

    // Reset in the middle of a write pulse
    do_cmd(1'b1, 11'h010, 8'h77);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_we", {31'd0, sram_we_n}, 32'd0);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    sbq.delete();
    known_m[11'h010] = 1'b0;
    last_rd    = '0;
    last_known = 1'b1;
    @(negedge clk);
    chk("midrst_state", {27'd0, bus.req_ready, sram_ce_n, sram_we_n, sram_oe_n, bus.done}, 32'b11110);
    chk("midrst_rd_data", bus.rd_data, 32'd0);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, bus.done}, 32'd0);
    end
    do_cmd(1'b1, 11'h010, 8'h5A);
    do_cmd(1'b0, 11'h010, 8'h00);
    idle(1);

    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
